// File: rtl/cond_pkg.sv
// Shared definitions for the ARM-style conditional-execution unit:
// condition codes, NZCV bit positions and flag-write group indices.
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'h0,
        NE = 4'h1,
        CS = 4'h2,
        CC = 4'h3,
        MI = 4'h4,
        PL = 4'h5,
        VS = 4'h6,
        VC = 4'h7,
        HI = 4'h8,
        LS = 4'h9,
        GE = 4'hA,
        LT = 4'hB,
        GT = 4'hC,
        LE = 4'hD,
        AL = 4'hE
    } cond_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // FlagWE bit that enables each flag group.
    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluator: pass=1 when the condition field
// holds for the given NZCV flags. Code 4'hF is treated as always-pass.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = flags[FLAG_N];
    assign w_z = flags[FLAG_Z];
    assign w_c = flags[FLAG_C];
    assign w_v = flags[FLAG_V];

    // NOTE: a default arm on the case covers every encoding, so no latch forms.
    always_comb begin
        case (cond)
            EQ:      pass = w_z;
            NE:      pass = !w_z;
            CS:      pass = w_c;
            CC:      pass = !w_c;
            MI:      pass = w_n;
            PL:      pass = !w_n;
            VS:      pass = w_v;
            VC:      pass = !w_v;
            HI:      pass = w_c && !w_z;
            LS:      pass = !w_c || w_z;
            GE:      pass = (w_n == w_v);
            LT:      pass = (w_n != w_v);
            GT:      pass = !w_z && (w_n == w_v);
            LE:      pass = w_z || (w_n != w_v);
            default: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_exec_unit.sv
// Execute-stage conditional logic: holds the architectural NZCV register,
// resolves branch-taken, and registers condition-gated controls into M.
module cond_exec_unit
    import cond_pkg::*;
#(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       flush,
    input  logic [3:0] CondE,
    input  logic [1:0] FlagWE,
    input  logic [3:0] ALUFlagsE,
    input  logic       RegWriteE,
    input  logic       MemWriteE,
    input  logic       MemtoRegE,
    input  logic       BranchE,
    input  logic       NoWriteE,
    output logic       CondExE,
    output logic       PCSrcE,
    output logic [3:0] FlagsE,
    output logic       RegWriteM,
    output logic       MemWriteM,
    output logic       MemtoRegM
);

    logic [3:0] r_flags;
    logic       r_reg_write_m;
    logic       r_mem_write_m;
    logic       r_mem_to_reg_m;
    logic       w_cond_ex;

    // Evaluated against the stored flags, so a flag-setting instruction
    // affects only the instructions that follow it.
    cond_check u_cond_check (
        .cond  (CondE),
        .flags (r_flags),
        .pass  (w_cond_ex)
    );

    // NOTE: reset is synchronous here and state uses non-blocking assignments,
    // so every register samples its next value from the same pre-edge state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= FLAGS_RST;
        end else if (!stall && w_cond_ex) begin
            if (FlagWE[FW_NZ])
                r_flags[FLAG_N:FLAG_Z] <= ALUFlagsE[FLAG_N:FLAG_Z];
            if (FlagWE[FW_CV])
                r_flags[FLAG_C:FLAG_V] <= ALUFlagsE[FLAG_C:FLAG_V];
        end
    end

    // Flush inserts a bubble even while stalled; it never touches the flags.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_reg_write_m  <= 1'b0;
            r_mem_write_m  <= 1'b0;
            r_mem_to_reg_m <= 1'b0;
        end else if (!stall) begin
            r_reg_write_m  <= RegWriteE && w_cond_ex && !NoWriteE;
            r_mem_write_m  <= MemWriteE && w_cond_ex;
            r_mem_to_reg_m <= MemtoRegE;
        end
    end

    assign CondExE   = w_cond_ex;
    assign PCSrcE    = BranchE && w_cond_ex;
    assign FlagsE    = r_flags;
    assign RegWriteM = r_reg_write_m;
    assign MemWriteM = r_mem_write_m;
    assign MemtoRegM = r_mem_to_reg_m;

endmodule

// File: tb/tb_cond_exec_unit.sv
// Scoreboard bench for cond_exec_unit: directed vectors carry hand-computed
// expectations; a separate monitor pops and compares them each cycle.
module tb_cond_exec_unit;

    localparam logic [3:0] FLAGS_RST_TB = 4'b0010;

    logic       clk = 1'b0;
    logic       rst, stall, flush;
    logic [3:0] CondE;
    logic [1:0] FlagWE;
    logic [3:0] ALUFlagsE;
    logic       RegWriteE, MemWriteE, MemtoRegE, BranchE, NoWriteE;
    logic       CondExE, PCSrcE;
    logic [3:0] FlagsE;
    logic       RegWriteM, MemWriteM, MemtoRegM;

    always #5 clk = ~clk;

    cond_exec_unit #(.FLAGS_RST(FLAGS_RST_TB)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .CondE     (CondE),
        .FlagWE    (FlagWE),
        .ALUFlagsE (ALUFlagsE),
        .RegWriteE (RegWriteE),
        .MemWriteE (MemWriteE),
        .MemtoRegE (MemtoRegE),
        .BranchE   (BranchE),
        .NoWriteE  (NoWriteE),
        .CondExE   (CondExE),
        .PCSrcE    (PCSrcE),
        .FlagsE    (FlagsE),
        .RegWriteM (RegWriteM),
        .MemWriteM (MemWriteM),
        .MemtoRegM (MemtoRegM)
    );

    // One stimulus vector plus the expected response: cx/pc for the same
    // cycle, fl/rwm/mwm/m2rm for the state after the following edge.
    typedef struct {
        logic       rst, stall, flush;
        logic [3:0] cond;
        logic [1:0] fwe;
        logic [3:0] alu;
        logic       rw, mw, m2r, br, nw;
        logic       cx, pc;
        logic [3:0] fl;
        logic       rwm, mwm, m2rm;
    } vec_t;

    // What the monitor checks at one negedge.
    typedef struct {
        int         idx;
        bit         chk_comb, chk_reg;
        logic       cx, pc;
        logic [3:0] fl;
        logic       rwm, mwm, m2rm;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   items_done = 0;

    function automatic vec_t mk(
        input logic r, input logic s, input logic f, input logic [3:0] c,
        input logic [1:0] we, input logic [3:0] a,
        input logic rw, input logic mw, input logic m2r, input logic br, input logic nw,
        input logic cx, input logic pc, input logic [3:0] fl,
        input logic rwm, input logic mwm, input logic m2rm);
        vec_t v;
        v.rst = r; v.stall = s; v.flush = f; v.cond = c; v.fwe = we; v.alu = a;
        v.rw = rw; v.mw = mw; v.m2r = m2r; v.br = br; v.nw = nw;
        v.cx = cx; v.pc = pc; v.fl = fl; v.rwm = rwm; v.mwm = mwm; v.m2rm = m2rm;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d got=%b expected=%b", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        rst = v.rst; stall = v.stall; flush = v.flush; CondE = v.cond;
        FlagWE = v.fwe; ALUFlagsE = v.alu; RegWriteE = v.rw; MemWriteE = v.mw;
        MemtoRegE = v.m2r; BranchE = v.br; NoWriteE = v.nw;
    endtask

    // Monitor: outputs are sampled on the falling edge, clear of the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk_comb) begin
                    check("CondExE", e.idx, {3'b0, CondExE}, {3'b0, e.cx});
                    check("PCSrcE",  e.idx, {3'b0, PCSrcE},  {3'b0, e.pc});
                end
                if (e.chk_reg) begin
                    check("FlagsE",    e.idx, FlagsE,              e.fl);
                    check("RegWriteM", e.idx, {3'b0, RegWriteM},   {3'b0, e.rwm});
                    check("MemWriteM", e.idx, {3'b0, MemWriteM},   {3'b0, e.mwm});
                    check("MemtoRegM", e.idx, {3'b0, MemtoRegM},   {3'b0, e.m2rm});
                end
                items_done++;
            end
        end
    end

    // Stimulus: apply vector k, push comb expectations for k together with
    // the registered expectations produced by vector k-1.
    initial begin
        exp_t e;
        vec_t prev;
        int   n_items = 0;
        int   wait_cycles = 0;

        //        rst st fl cond   fwe    alu      rw mw m2 br nw  cx pc fl       rwm mwm m2rm
        vecs.push_back(mk(1, 0, 0, 4'hE, 2'b00, 4'b0000, 0, 0, 0, 1, 0,  1, 1, 4'b0010, 0, 0, 0)); // reset, AL branch
        vecs.push_back(mk(1, 0, 0, 4'h2, 2'b00, 4'b0000, 1, 0, 0, 1, 0,  1, 1, 4'b0010, 0, 0, 0)); // reset held, CS on reset flags
        vecs.push_back(mk(0, 0, 0, 4'hE, 2'b11, 4'b0100, 1, 0, 1, 0, 0,  1, 0, 4'b0100, 1, 0, 1)); // AL sets Z
        vecs.push_back(mk(0, 0, 0, 4'h0, 2'b00, 4'b0000, 0, 1, 0, 1, 0,  1, 1, 4'b0100, 0, 1, 0)); // EQ sees new Z
        vecs.push_back(mk(0, 0, 0, 4'hE, 2'b11, 4'b0000, 0, 0, 0, 0, 0,  1, 0, 4'b0000, 0, 0, 0)); // clear flags
        vecs.push_back(mk(0, 0, 0, 4'h0, 2'b11, 4'b1111, 1, 1, 0, 1, 0,  0, 0, 4'b0000, 0, 0, 0)); // EQ fails: no writes
        vecs.push_back(mk(0, 0, 0, 4'hE, 2'b11, 4'b1001, 0, 0, 0, 0, 0,  1, 0, 4'b1001, 0, 0, 0)); // flags = 1001
        vecs.push_back(mk(0, 0, 0, 4'hA, 2'b01, 4'b0110, 1, 0, 1, 0, 0,  1, 0, 4'b1010, 1, 0, 1)); // GE, C/V group only
        vecs.push_back(mk(0, 0, 0, 4'hE, 2'b11, 4'b0011, 1, 1, 0, 0, 1,  1, 0, 4'b0011, 0, 1, 0)); // CMP: NoWrite
        vecs.push_back(mk(0, 0, 0, 4'hB, 2'b10, 4'b1100, 1, 0, 0, 0, 0,  1, 0, 4'b1111, 1, 0, 0)); // LT, N/Z group only
        vecs.push_back(mk(0, 0, 0, 4'hE, 2'b00, 4'b0000, 1, 1, 1, 0, 0,  1, 0, 4'b1111, 1, 1, 1)); // load M regs
        vecs.push_back(mk(0, 1, 0, 4'hE, 2'b11, 4'b0000, 0, 0, 0, 1, 0,  1, 1, 4'b1111, 1, 1, 1)); // stall holds all
        vecs.push_back(mk(0, 1, 1, 4'hE, 2'b11, 4'b0000, 1, 0, 0, 0, 0,  1, 0, 4'b1111, 0, 0, 0)); // stall+flush
        vecs.push_back(mk(0, 0, 1, 4'h8, 2'b11, 4'b0000, 1, 0, 0, 0, 0,  0, 0, 4'b1111, 0, 0, 0)); // flush, HI fails
        vecs.push_back(mk(0, 0, 1, 4'h9, 2'b11, 4'b0110, 1, 1, 0, 1, 0,  1, 1, 4'b0110, 0, 0, 0)); // flush, LS passes: flags write
        vecs.push_back(mk(0, 0, 0, 4'hC, 2'b00, 4'b0000, 1, 0, 1, 1, 0,  0, 0, 4'b0110, 0, 0, 1)); // GT fails, MemtoReg ungated
        vecs.push_back(mk(1, 0, 0, 4'hE, 2'b11, 4'b1101, 1, 1, 1, 0, 0,  1, 0, 4'b0010, 0, 0, 0)); // reset wins over flag write
        vecs.push_back(mk(0, 0, 0, 4'hF, 2'b00, 4'b0000, 0, 0, 0, 1, 0,  1, 1, 4'b0010, 0, 0, 0)); // 4'hF always passes
        vecs.push_back(mk(0, 0, 0, 4'h1, 2'b00, 4'b0000, 0, 0, 0, 1, 0,  1, 1, 4'b0010, 0, 0, 0)); // NE
        vecs.push_back(mk(0, 0, 0, 4'h3, 2'b00, 4'b0000, 0, 0, 0, 1, 0,  0, 0, 4'b0010, 0, 0, 0)); // CC fails (C=1)

        apply(mk(1, 0, 0, 4'h0, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0));

        foreach (vecs[k]) begin
            @(posedge clk);
            #1;
            apply(vecs[k]);
            e.idx      = k;
            e.chk_comb = 1'b1;
            e.chk_reg  = (k > 0);
            e.cx       = vecs[k].cx;
            e.pc       = vecs[k].pc;
            e.fl       = prev.fl;
            e.rwm      = prev.rwm;
            e.mwm      = prev.mwm;
            e.m2rm     = prev.m2rm;
            sb.push_back(e);
            n_items++;
            prev = vecs[k];
        end

        // Drain: one more cycle to observe the last vector's registered result.
        @(posedge clk);
        #1;
        apply(mk(0, 1, 0, 4'hE, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
        e.idx      = vecs.size();
        e.chk_comb = 1'b0;
        e.chk_reg  = 1'b1;
        e.fl       = prev.fl;
        e.rwm      = prev.rwm;
        e.mwm      = prev.mwm;
        e.m2rm     = prev.m2rm;
        sb.push_back(e);
        n_items++;

        while (items_done < n_items && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        checks++;
        if (items_done < n_items) begin
            errors++;
            $display("FAIL drain_timeout got=%0d expected=%0d items", items_done, n_items);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
